regfile_sb: RTL and testbench

//  Parametrised integer register file with load-writeback extension and a
//  per-register busy scoreboard. Sits in the decode stage; serves NRD read

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback, long-latency issue and scoreboard status.
// The master side (decode/issue logic) drives addresses and strobes; the slave is the register file.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NRD  = 2,
    parameter int AW   = 5
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                wr_ld;
    logic [2:0]          wr_fmt;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ack;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_ld, wr_fmt, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ack, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_ld, wr_fmt, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ack, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with load-extension on writeback and a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data/busy-clear to the read ports.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    // Load result shaping by funct3; unknown formats pass the raw word.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                                 input logic            ld,
                                                 input logic [2:0]      fmt);
        logic [XLEN-1:0] r;
        r = d;
        if (ld) begin
            case (fmt)
                3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
                3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
                3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
                3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;

    logic [XLEN-1:0]     wr_ext_s;
    logic                wr_do_s;
    logic                iss_ack_s;
    logic                set_s, clr_s;
    logic [NRD*XLEN-1:0] rd_data_s;
    logic [NRD-1:0]      rd_busy_s;

    // Writeback, issue acceptance and scoreboard next-state.
    always_comb begin
        wr_ext_s   = load_ext(bus.wr_data, bus.wr_ld, bus.wr_fmt);
        wr_do_s    = bus.wr_en && (bus.wr_addr != {AW{1'b0}});
        iss_ack_s  = bus.iss_en && ((bus.iss_addr == {AW{1'b0}}) || !busy_q[bus.iss_addr]);
        set_s      = iss_ack_s && (bus.iss_addr != {AW{1'b0}});
        // busy[0] is never set, so a busy hit already implies a nonzero address.
        clr_s      = bus.wr_en && busy_q[bus.wr_addr];
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_do_s) begin
            regs_d[bus.wr_addr] = wr_ext_s;
        end else begin
            regs_d = regs_q;
        end
        if (clr_s) begin
            busy_d[bus.wr_addr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        // A set needs a non-busy target and a clear a busy one, so they never collide.
        if (set_s) begin
            busy_d[bus.iss_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (set_s && !clr_s) begin
            busy_cnt_d = busy_cnt_q + (AW+1)'(1);
        end else if (clr_s && !set_s) begin
            busy_cnt_d = busy_cnt_q - (AW+1)'(1);
        end else begin
            busy_cnt_d = busy_cnt_q;
        end
    end

    // State registers: register array, busy bits and busy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(AW+1){1'b0}};
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports with x0 forced to zero and optional forwarding.
    always_comb begin
        rd_data_s = {(NRD*XLEN){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (bus.rd_addr[k*AW +: AW] == {AW{1'b0}}) begin
                rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy_s[k]              = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (wr_do_s && (bus.wr_addr == bus.rd_addr[k*AW +: AW])) begin
                    rd_data_s[k*XLEN +: XLEN] = wr_ext_s;
                    rd_busy_s[k]              = 1'b0;
                end else begin
                    rd_data_s[k*XLEN +: XLEN] = regs_q[bus.rd_addr[k*AW +: AW]];
                    rd_busy_s[k]              = busy_q[bus.rd_addr[k*AW +: AW]];
                end
`else
                rd_data_s[k*XLEN +: XLEN] = regs_q[bus.rd_addr[k*AW +: AW]];
                rd_busy_s[k]              = busy_q[bus.rd_addr[k*AW +: AW]];
`endif
            end
        end
    end

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.iss_ack  = iss_ack_s;
    assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default two read ports, 32x32).
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    regfile_sb_if #(.XLEN(XLEN), .NRD(NRD), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'h0;
        bus.wr_ld    = 1'b0;
        bus.wr_fmt   = 3'b000;
        bus.iss_en   = 1'b0;
        bus.iss_addr = 5'd0;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d, input logic ld, input logic [2:0] f);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_ld = ld; bus.wr_fmt = f;
        tick();
        idle();
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        set_rd(5'd5, 5'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        tick();
        total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=%h", bus.rd_data[31:0], 32'h0); end
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.busy_cnt); end
        idle();
        reset = 1'b1;
        tick();
        total++; if (bus.rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL rst_x5 got=%h exp=%h", bus.rd_data[31:0], 32'h0); end
        total++; if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b exp=00", bus.rd_busy); end
    endtask

    task automatic test_ext();
        set_rd(5'd3, 5'd0);
        do_wb(5'd3, 32'h00000080, 1'b1, 3'b000);
        total++; if (bus.rd_data[31:0] !== 32'hFFFFFF80) begin bad++; $display("FAIL ext_lb got=%h exp=FFFFFF80", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'h00000080, 1'b1, 3'b100);
        total++; if (bus.rd_data[31:0] !== 32'h00000080) begin bad++; $display("FAIL ext_lbu got=%h exp=00000080", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'h0000F00F, 1'b1, 3'b101);
        total++; if (bus.rd_data[31:0] !== 32'h0000F00F) begin bad++; $display("FAIL ext_lhu got=%h exp=0000F00F", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'h0000F00F, 1'b1, 3'b001);
        total++; if (bus.rd_data[31:0] !== 32'hFFFFF00F) begin bad++; $display("FAIL ext_lh got=%h exp=FFFFF00F", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'hCAFEBABE, 1'b1, 3'b010);
        total++; if (bus.rd_data[31:0] !== 32'hCAFEBABE) begin bad++; $display("FAIL ext_lw got=%h exp=CAFEBABE", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'h80000080, 1'b0, 3'b000);
        total++; if (bus.rd_data[31:0] !== 32'h80000080) begin bad++; $display("FAIL ext_raw got=%h exp=80000080", bus.rd_data[31:0]); end
        do_wb(5'd3, 32'h12345687, 1'b1, 3'b111);
        total++; if (bus.rd_data[31:0] !== 32'h12345687) begin bad++; $display("FAIL ext_other got=%h exp=12345687", bus.rd_data[31:0]); end
    endtask

    task automatic test_scoreboard();
        set_rd(5'd7, 5'd0);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        #1;
        total++; if (bus.iss_ack !== 1'b1) begin bad++; $display("FAIL sb_ack1 got=%b exp=1", bus.iss_ack); end
        tick();
        total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_cnt1 got=%0d exp=1", bus.busy_cnt); end
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_busy1 got=%b exp=1", bus.rd_busy[0]); end
        total++; if (bus.iss_ack !== 1'b0) begin bad++; $display("FAIL sb_waw got=%b exp=0", bus.iss_ack); end
        tick();
        total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_cnt_hold got=%0d exp=1", bus.busy_cnt); end
        idle();
        do_wb(5'd7, 32'h12, 1'b0, 3'b000);
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL sb_cnt0 got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_busy0 got=%b exp=0", bus.rd_busy[0]); end
        total++; if (bus.rd_data[31:0] !== 32'h12) begin bad++; $display("FAIL sb_data got=%h exp=00000012", bus.rd_data[31:0]); end
        // busy x7 again, then writeback + re-issue in the same cycle
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h34;
        #1;
        total++; if (bus.iss_ack !== 1'b0) begin bad++; $display("FAIL sb_wb_iss_ack got=%b exp=0", bus.iss_ack); end
        tick();
        bus.wr_en = 1'b0;
        #1;
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL sb_wb_iss_cnt got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.iss_ack !== 1'b1) begin bad++; $display("FAIL sb_retry_ack got=%b exp=1", bus.iss_ack); end
        tick();
        idle();
        total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_retry_cnt got=%0d exp=1", bus.busy_cnt); end
        do_wb(5'd7, 32'h56, 1'b0, 3'b000);
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL sb_final_cnt got=%0d exp=0", bus.busy_cnt); end
    endtask

    task automatic test_same_cycle();
        set_rd(5'd4, 5'd9);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h44;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        #1;
        total++; if (bus.iss_ack !== 1'b1) begin bad++; $display("FAIL sc_ack got=%b exp=1", bus.iss_ack); end
        tick();
        idle();
        #1;
        total++; if (bus.rd_data[31:0] !== 32'h44) begin bad++; $display("FAIL sc_data got=%h exp=00000044", bus.rd_data[31:0]); end
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sc_busy4 got=%b exp=1", bus.rd_busy[0]); end
        total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL sc_cnt1 got=%0d exp=1", bus.busy_cnt); end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        tick();
        total++; if (bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL sc_cnt2 got=%0d exp=2", bus.busy_cnt); end
        bus.iss_addr = 5'd8;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
        tick();
        idle();
        #1;
        total++; if (bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL sc_setclr_cnt got=%0d exp=2", bus.busy_cnt); end
        total++; if (bus.rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sc_busy9 got=%b exp=0", bus.rd_busy[1]); end
        set_rd(5'd8, 5'd9);
        total++; if (bus.rd_busy !== 2'b01) begin bad++; $display("FAIL sc_busy8 got=%b exp=01", bus.rd_busy); end
        do_wb(5'd10, 32'hA0, 1'b0, 3'b000);
        total++; if (bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL sc_alu_wb_cnt got=%0d exp=2", bus.busy_cnt); end
        do_wb(5'd4, 32'h4, 1'b0, 3'b000);
        do_wb(5'd8, 32'h8, 1'b0, 3'b000);
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL sc_drain_cnt got=%0d exp=0", bus.busy_cnt); end
    endtask

    task automatic test_x0();
        set_rd(5'd0, 5'd0);
        do_wb(5'd0, 32'hFFFFFFFF, 1'b0, 3'b000);
        total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL x0_data got=%h exp=0", bus.rd_data); end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        #1;
        total++; if (bus.iss_ack !== 1'b1) begin bad++; $display("FAIL x0_ack got=%b exp=1", bus.iss_ack); end
        tick();
        idle();
        #1;
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL x0_busy got=%b exp=00", bus.rd_busy); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        set_rd(5'd2, 5'd0);
        do_wb(5'd2, 32'h11, 1'b0, 3'b000);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h55;
`else
        exp_d = 32'h11;
`endif
        total++; if (bus.rd_data[31:0] !== exp_d) begin bad++; $display("FAIL byp_data got=%h exp=%h", bus.rd_data[31:0], exp_d); end
        tick();
        idle();
        #1;
        total++; if (bus.rd_data[31:0] !== 32'h55) begin bad++; $display("FAIL byp_after got=%h exp=00000055", bus.rd_data[31:0]); end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd2;
        tick();
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h66;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        total++; if (bus.rd_busy[0] !== exp_b) begin bad++; $display("FAIL byp_busy got=%b exp=%b", bus.rd_busy[0], exp_b); end
        tick();
        idle();
        #1;
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL byp_cnt got=%0d exp=0", bus.busy_cnt); end
        // async reset drops pending busy bits without waiting for a clock edge
        set_rd(5'd12, 5'd13);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
        tick();
        bus.iss_addr = 5'd13;
        tick();
        idle();
        total++; if (bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL ar_pre_cnt got=%0d exp=2", bus.busy_cnt); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", bus.busy_cnt); end
        total++; if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL ar_busy got=%b exp=00", bus.rd_busy); end
        tick();
        reset = 1'b1;
        do_wb(5'd12, 32'h99, 1'b0, 3'b000);
        total++; if (bus.rd_data[31:0] !== 32'h99) begin bad++; $display("FAIL ar_late_wb got=%h exp=00000099", bus.rd_data[31:0]); end
        total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL ar_late_cnt got=%0d exp=0", bus.busy_cnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.rd_addr = '0;
        test_reset();
        test_ext();
        test_scoreboard();
        test_same_cycle();
        test_x0();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
